fetch_pipe_ctrl: RTL and testbench

Consumes the load-use hazard unit's outputs (is_stall, IF_ID_write_enable, ID_EX_flush) and applies them to the front of the 5-stage pipeline. Owns the PC register and the IF/ID pipeline register. Arbitrates stall, EX-stage branch/jump redirect, and external interrupt entry/return, and produces the ID/EX bubble request. Sits between instruction memory and the decode stage.

---
 rtl/fetch_pipe_if.sv | 40 ++++
 rtl/fetch_pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_pipe_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pipe_if.sv
// Front-end bus of the fetch controller: hazard-unit inputs, EX redirect/mret,
// IMEM read data, interrupt lines, and the IF/ID and status outputs.
interface fetch_pipe_if #(
  parameter int CNT_W = 16
);
  logic             is_stall;
  logic             IF_ID_write_enable;
  logic             ID_EX_flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [31:0]      imem_inst;
  logic             int_req;
  logic [31:0]      int_vec;
  logic             mret;
  logic [31:0]      pc_out;
  logic [31:0]      IF_ID_pc;
  logic [31:0]      IF_ID_inst;
  logic             IF_ID_valid;
  logic             ID_EX_bubble;
  logic             int_ack;
  logic [31:0]      epc;
  logic             in_handler;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             hz_err;

  modport master (
    output is_stall, IF_ID_write_enable, ID_EX_flush, redirect_valid, redirect_pc,
           imem_inst, int_req, int_vec, mret,
    input  pc_out, IF_ID_pc, IF_ID_inst, IF_ID_valid, ID_EX_bubble, int_ack, epc,
           in_handler, stall_cnt, flush_cnt, hz_err
  );

  modport slave (
    input  is_stall, IF_ID_write_enable, ID_EX_flush, redirect_valid, redirect_pc,
           imem_inst, int_req, int_vec, mret,
    output pc_out, IF_ID_pc, IF_ID_inst, IF_ID_valid, ID_EX_bubble, int_ack, epc,
           in_handler, stall_cnt, flush_cnt, hz_err
  );
endinterface

// File: rtl/fetch_pipe_ctrl.sv
// Pipeline front end: PC and IF/ID register, arbitrating redirect, mret,
// interrupt entry, load-use stall and normal fetch in that priority order.
module fetch_pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rstn,
  fetch_pipe_if.slave bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, HANDLER} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifpc_q, ifpc_d;
  logic [31:0]      ifinst_q, ifinst_d;
  logic             ifvld_q, ifvld_d;
  logic [31:0]      epc_q, epc_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             hz_q, hz_d;
  logic             stall_req;
  logic             take_int;
  logic             bubble;
  logic             ack;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign stall_req = bus.is_stall | ~bus.IF_ID_write_enable;
  // Interrupts only enter on a clean boundary so epc names a real instruction.
  assign take_int  = bus.int_req & (state_q == RUN) & ~stall_req & ifvld_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ifpc_d   = ifpc_q;
    ifinst_d = ifinst_q;
    ifvld_d  = ifvld_q;
    epc_d    = epc_q;
    scnt_d   = scnt_q;
    fcnt_d   = fcnt_q;
    hz_d     = hz_q | (bus.is_stall == bus.IF_ID_write_enable);
    bubble   = bus.ID_EX_flush;
    ack      = 1'b0;
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      ifvld_d  = 1'b0;
      ifinst_d = NOP;
      fcnt_d   = sat_inc(fcnt_q);
      bubble   = 1'b1;
    end else if (bus.mret) begin
      pc_d     = epc_q;
      state_d  = RUN;
      ifvld_d  = 1'b0;
      ifinst_d = NOP;
      fcnt_d   = sat_inc(fcnt_q);
      bubble   = 1'b1;
    end else if (take_int) begin
      epc_d    = ifpc_q;
      pc_d     = bus.int_vec;
      state_d  = HANDLER;
      ifvld_d  = 1'b0;
      ifinst_d = NOP;
      fcnt_d   = sat_inc(fcnt_q);
      bubble   = 1'b1;
      ack      = 1'b1;
    end else if (stall_req) begin
      bubble   = bus.ID_EX_flush | bus.is_stall;
      scnt_d   = sat_inc(scnt_q);
    end else begin
      ifpc_d   = pc_q;
      ifinst_d = bus.imem_inst;
      ifvld_d  = 1'b1;
      pc_d     = pc_q + 32'd4;
    end
  end

  // IF -> ID stage boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      ifpc_q   <= 32'h0;
      ifinst_q <= NOP;
      ifvld_q  <= 1'b0;
      epc_q    <= 32'h0;
      scnt_q   <= '0;
      fcnt_q   <= '0;
      hz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ifpc_q   <= ifpc_d;
      ifinst_q <= ifinst_d;
      ifvld_q  <= ifvld_d;
      epc_q    <= epc_d;
      scnt_q   <= scnt_d;
      fcnt_q   <= fcnt_d;
      hz_q     <= hz_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.IF_ID_pc     = ifpc_q;
  assign bus.IF_ID_inst   = ifinst_q;
  assign bus.IF_ID_valid  = ifvld_q;
  assign bus.ID_EX_bubble = bubble;
  assign bus.int_ack      = ack;
  assign bus.epc          = epc_q;
  assign bus.in_handler   = (state_q == HANDLER);
  assign bus.stall_cnt    = scnt_q;
  assign bus.flush_cnt    = fcnt_q;
  assign bus.hz_err       = hz_q;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Scoreboard bench for fetch_pipe_ctrl: a behavioural model pushes the expected
// post-edge state each cycle, which is popped and compared after the edge.
module tb_fetch_pipe_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  fetch_pipe_if #(.CNT_W(16)) bus ();

  fetch_pipe_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0300;
  endfunction

  assign bus.imem_inst = imem_f(bus.pc_out);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifinst;
    logic [31:0] epc;
    logic        ifvld;
    logic        inh;
    logic        hz;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    m.pc = 32'h0; m.ifpc = 32'h0; m.ifinst = NOP; m.epc = 32'h0;
    m.ifvld = 1'b0; m.inh = 1'b0; m.hz = 1'b0; m.scnt = 16'h0; m.fcnt = 16'h0;
  endtask

  task automatic drv(input logic st, input logic we, input logic fl, input logic rv,
                     input logic [31:0] rpc, input logic ir, input logic [31:0] iv,
                     input logic mr);
    bus.is_stall = st; bus.IF_ID_write_enable = we; bus.ID_EX_flush = fl;
    bus.redirect_valid = rv; bus.redirect_pc = rpc;
    bus.int_req = ir; bus.int_vec = iv; bus.mret = mr;
  endtask

  task automatic idle();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic check_state(input exp_t e);
    check_eq("pc_out", bus.pc_out, e.pc);
    check_eq("IF_ID_pc", bus.IF_ID_pc, e.ifpc);
    check_eq("IF_ID_inst", bus.IF_ID_inst, e.ifinst);
    check_eq("IF_ID_valid", bus.IF_ID_valid, e.ifvld);
    check_eq("epc", bus.epc, e.epc);
    check_eq("in_handler", bus.in_handler, e.inh);
    check_eq("hz_err", bus.hz_err, e.hz);
    check_eq("stall_cnt", bus.stall_cnt, e.scnt);
    check_eq("flush_cnt", bus.flush_cnt, e.fcnt);
  endtask

  task automatic tick(input bit quiet);
    exp_t n;
    exp_t got;
    logic sreq, bub, ack;
    #1;
    n    = m;
    sreq = bus.is_stall | ~bus.IF_ID_write_enable;
    bub  = bus.ID_EX_flush;
    ack  = 1'b0;
    if (bus.is_stall == bus.IF_ID_write_enable) n.hz = 1'b1;
    if (bus.redirect_valid) begin
      n.pc = bus.redirect_pc; n.ifvld = 1'b0; n.ifinst = NOP; n.fcnt = sat16(m.fcnt); bub = 1'b1;
    end else if (bus.mret) begin
      n.pc = m.epc; n.inh = 1'b0; n.ifvld = 1'b0; n.ifinst = NOP; n.fcnt = sat16(m.fcnt); bub = 1'b1;
    end else if (bus.int_req && !m.inh && !sreq && m.ifvld) begin
      n.epc = m.ifpc; n.pc = bus.int_vec; n.inh = 1'b1; n.ifvld = 1'b0; n.ifinst = NOP;
      n.fcnt = sat16(m.fcnt); bub = 1'b1; ack = 1'b1;
    end else if (sreq) begin
      bub = bus.ID_EX_flush | bus.is_stall; n.scnt = sat16(m.scnt);
    end else begin
      n.ifpc = m.pc; n.ifinst = imem_f(m.pc); n.ifvld = 1'b1; n.pc = m.pc + 32'd4;
    end
    if (!quiet) begin
      check_eq("ID_EX_bubble", bus.ID_EX_bubble, bub);
      check_eq("int_ack", bus.int_ack, ack);
    end
    sb.push_back(n);
    m = n;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (!quiet) check_state(got);
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    #1;
    check_eq("rst_pc_out", bus.pc_out, 32'h0);
    check_eq("rst_IF_ID_pc", bus.IF_ID_pc, 32'h0);
    check_eq("rst_IF_ID_inst", bus.IF_ID_inst, NOP);
    check_eq("rst_IF_ID_valid", bus.IF_ID_valid, 1'b0);
    check_eq("rst_epc", bus.epc, 32'h0);
    check_eq("rst_in_handler", bus.in_handler, 1'b0);
    check_eq("rst_int_ack", bus.int_ack, 1'b0);
    check_eq("rst_stall_cnt", bus.stall_cnt, 16'h0);
    check_eq("rst_flush_cnt", bus.flush_cnt, 16'h0);
    check_eq("rst_hz_err", bus.hz_err, 1'b0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    idle();
    #2;
    do_reset();

    repeat (3) tick(0);
    check_eq("seq_pc", bus.pc_out, 32'hC);
    check_eq("seq_ifpc", bus.IF_ID_pc, 32'h8);
    tick(0);

    drv(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) tick(0);
    check_eq("stall_pc_held", bus.pc_out, 32'h10);
    check_eq("stall_cnt_2", bus.stall_cnt, 16'd2);
    idle();
    tick(0);
    check_eq("post_stall_pc", bus.pc_out, 32'h14);

    drv(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    tick(0);
    check_eq("redir_pc", bus.pc_out, 32'h100);
    check_eq("redir_inst", bus.IF_ID_inst, NOP);
    check_eq("redir_flush_cnt", bus.flush_cnt, 16'd1);
    check_eq("redir_stall_cnt", bus.stall_cnt, 16'd2);

    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
    tick(0);
    idle();
    repeat (2) tick(0);
    check_eq("pre_int_ifpc", bus.IF_ID_pc, 32'h24);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    tick(0);
    check_eq("int_epc", bus.epc, 32'h24);
    check_eq("int_pc", bus.pc_out, 32'h200);
    check_eq("int_in_handler", bus.in_handler, 1'b1);
    repeat (3) tick(0);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0);
    tick(0);
    check_eq("redir_in_handler", bus.in_handler, 1'b1);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick(0);
    check_eq("mret_pc", bus.pc_out, 32'h24);
    check_eq("mret_in_handler", bus.in_handler, 1'b0);

    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
    tick(0);
    tick(0);
    check_eq("deferred_int_pc", bus.pc_out, 32'h400);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick(0);
    idle();
    repeat (2) tick(0);
    drv(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
    tick(0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick(0);
    check_eq("mret_run_pc", bus.pc_out, 32'h24);

    drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(0);
    check_eq("hz_set", bus.hz_err, 1'b1);
    idle();
    repeat (2) tick(0);
    check_eq("hz_sticky", bus.hz_err, 1'b1);

    for (int i = 0; i < 300; i++) begin
      logic st;
      st = ($urandom_range(0, 4) == 0);
      drv(st, ~st, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
          {$urandom_range(0, 16'hFFFF), 2'b00}, ($urandom_range(0, 4) == 0),
          {$urandom_range(0, 16'hFFFF), 2'b00}, ($urandom_range(0, 19) == 0));
      tick(0);
    end

    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick(0);
    idle();
    tick(0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0);
    tick(0);
    check_eq("pre_rst_in_handler", bus.in_handler, 1'b1);
    do_reset();

    drv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (65534) tick(1);
    check_eq("stall_cnt_fffe", bus.stall_cnt, 16'hFFFE);
    repeat (3) tick(0);
    check_eq("stall_cnt_sat", bus.stall_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
